// File: rtl/vend_pkg.sv
// Shared definitions for the change dispenser: change codes, upstream coin
// codes, dispenser FSM states and the queued request format.
package vend_pkg;

  // Change codes carried on the 2-bit change strobe (units of one 5-rs coin)
  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;
  localparam logic [1:0] CHG_15   = 2'b11;

  // Coin input codes used by the upstream vending FSM
  localparam logic [1:0] COIN_IN_NONE = 2'b00;
  localparam logic [1:0] COIN_IN_5    = 2'b01;
  localparam logic [1:0] COIN_IN_10   = 2'b10;

  // Dispenser FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_VEND     = 2'b01,
    ST_COIN_REQ = 2'b10,
    ST_COIN_GAP = 2'b11
  } disp_state_e;

  // One queued request: vend flag plus number of 5-rs coins to return
  typedef struct packed {
    logic       vend;
    logic [1:0] change;
  } vend_req_t;

  localparam int REQ_W = $bits(vend_req_t);

  // A cycle carries a request when either strobe is active
  function automatic logic is_request(input logic vend, input logic [1:0] change);
    return vend | (change != CHG_NONE);
  endfunction

endpackage

// File: rtl/vend_req_fifo.sv
// Small synchronous FIFO with show-ahead output. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module vend_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o    = (count_q == CNT_FULL);
  assign empty_o   = (count_q == CNT_ZERO);
  assign dout_o    = mem_q[rd_ptr_q];
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);

  // Next pointers and occupancy from the accepted push/pop pair
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful where count says so
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/vend_change_dispenser.sv
// Change dispenser: queues vend/change strobes from the vending FSM, runs the
// product motor and the 5-rs coin hopper through req/ack handshakes, keeps
// the coin stock and raises sticky fault flags.
module vend_change_dispenser #(
  parameter int FIFO_DEPTH = 4,
  parameter int COIN_W     = 8,
  parameter int INIT_COINS = 20,
  parameter int GAP        = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out,
  input  logic [1:0]        change,
  input  logic              refill,
  input  logic [COIN_W-1:0] refill_cnt,
  input  logic              clr_flags,
  output logic              motor_req,
  input  logic              motor_done,
  output logic              coin_req,
  input  logic              coin_ack,
  output logic [COIN_W-1:0] coins_left,
  output logic              busy,
  output logic              overflow,
  output logic              short_change,
  output logic              motor_fault
);

  import vend_pkg::*;

  // One timer serves both the motor watchdog and the inter-coin gap
  localparam int TMR_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0]  TMR_ZERO  = TMR_W'(0);
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0]  TMO_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  GAP_LAST  = TMR_W'(GAP - 1);
  localparam logic [COIN_W-1:0] COIN_ZERO = COIN_W'(0);
  localparam logic [COIN_W-1:0] COIN_ONE  = COIN_W'(1);
  localparam logic [COIN_W-1:0] COIN_INIT = COIN_W'(INIT_COINS);

  vend_req_t           req_in_s, head_s;
  logic                req_valid_s, fifo_full_s, fifo_empty_s, fifo_pop_s;
  logic                ovf_set_s, short_set_s, fault_set_s, coin_dec_s;

  disp_state_e         state_q, state_d;
  logic [1:0]          coin_cnt_q, coin_cnt_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [COIN_W-1:0]   coins_q, coins_d;
  logic                motor_req_q, motor_req_d;
  logic                coin_req_q, coin_req_d;
  logic                overflow_q, overflow_d;
  logic                short_q, short_d;
  logic                fault_q, fault_d;

  assign req_in_s    = {out, change};
  assign req_valid_s = is_request(out, change);
  // A request is lost only when the queue is full and nothing leaves it
  assign ovf_set_s   = req_valid_s & fifo_full_s & ~fifo_pop_s;

  vend_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_req_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (req_valid_s),
    .din_i   (req_in_s),
    .pop_i   (fifo_pop_s),
    .dout_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Dispenser FSM: serve one request at a time, product first, then coins
  always_comb begin
    state_d     = state_q;
    coin_cnt_d  = coin_cnt_q;
    timer_d     = timer_q;
    fifo_pop_s  = 1'b0;
    coin_dec_s  = 1'b0;
    short_set_s = 1'b0;
    fault_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = TMR_ZERO;
        if (!fifo_empty_s) begin
          // The vend decision is taken straight from the popped entry so
          // the handshake starts two cycles after the strobe.
          fifo_pop_s = 1'b1;
          coin_cnt_d = head_s.change;
          if (head_s.vend) begin
            state_d = ST_VEND;
          end else if (head_s.change != CHG_NONE) begin
            state_d = ST_COIN_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VEND: begin
        if (motor_done) begin
          timer_d = TMR_ZERO;
          state_d = (coin_cnt_q != 2'd0) ? ST_COIN_REQ : ST_IDLE;
        end else if (timer_q == TMO_LAST) begin
          fault_set_s = 1'b1;
          timer_d     = TMR_ZERO;
          state_d     = (coin_cnt_q != 2'd0) ? ST_COIN_REQ : ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      ST_COIN_REQ: begin
        if (coins_q == COIN_ZERO) begin
          // Stock exhausted: the rest of this change is forfeited
          short_set_s = 1'b1;
          coin_cnt_d  = 2'd0;
          state_d     = ST_IDLE;
        end else if (coin_ack) begin
          coin_dec_s = 1'b1;
          coin_cnt_d = coin_cnt_q - 2'd1;
          timer_d    = TMR_ZERO;
          state_d    = ST_COIN_GAP;
        end else begin
          state_d = ST_COIN_REQ;
        end
      end
      ST_COIN_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = TMR_ZERO;
          state_d = (coin_cnt_q != 2'd0) ? ST_COIN_REQ : ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        coin_cnt_d = 2'd0;
        timer_d    = TMR_ZERO;
      end
    endcase
  end

  // Coin stock, sticky flags and next values of the registered handshakes
  always_comb begin
    coins_d = coins_q;
    if (refill) begin
      coins_d = refill_cnt;
    end else if (coin_dec_s) begin
      coins_d = coins_q - COIN_ONE;
    end else begin
      coins_d = coins_q;
    end
    overflow_d  = (overflow_q & ~clr_flags) | ovf_set_s;
    short_d     = (short_q & ~clr_flags) | short_set_s;
    fault_d     = (fault_q & ~clr_flags) | fault_set_s;
    motor_req_d = (state_d == ST_VEND);
    // No coin is requested while the stock is empty
    coin_req_d  = (state_d == ST_COIN_REQ) & (coins_d != COIN_ZERO);
  end

  // State, counters, stock, flags and handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      coin_cnt_q  <= 2'd0;
      timer_q     <= TMR_ZERO;
      coins_q     <= COIN_INIT;
      motor_req_q <= 1'b0;
      coin_req_q  <= 1'b0;
      overflow_q  <= 1'b0;
      short_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      coin_cnt_q  <= coin_cnt_d;
      timer_q     <= timer_d;
      coins_q     <= coins_d;
      motor_req_q <= motor_req_d;
      coin_req_q  <= coin_req_d;
      overflow_q  <= overflow_d;
      short_q     <= short_d;
      fault_q     <= fault_d;
    end
  end

  assign motor_req    = motor_req_q;
  assign coin_req     = coin_req_q;
  assign coins_left   = coins_q;
  assign busy         = (state_q != ST_IDLE) | ~fifo_empty_s;
  assign overflow     = overflow_q;
  assign short_change = short_q;
  assign motor_fault  = fault_q;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Scoreboard bench for the change dispenser. Stimulus pushes the expected
// handshake events (motor, coin) into a queue computed from the request
// rules and the coin stock; a monitor pops and compares each observed event.
module tb_vend_change_dispenser;

  localparam int FIFO_DEPTH = 4;
  localparam int COIN_W     = 8;
  localparam int INIT_COINS = 20;
  localparam int GAP        = 2;
  localparam int TIMEOUT    = 255;
  localparam int EV_MOTOR   = 1;
  localparam int EV_COIN    = 2;

  logic              clk = 1'b0;
  logic              rst, out, refill, clr_flags;
  logic [1:0]        change;
  logic [COIN_W-1:0] refill_cnt;
  logic              motor_req, motor_done, coin_req, coin_ack;
  logic [COIN_W-1:0] coins_left;
  logic              busy, overflow, short_change, motor_fault;

  int n_cmp = 0;
  int n_bad = 0;
  int expq[$];
  int stock_m;
  bit short_exp, ovf_exp, fault_exp;
  int cyc = 0;
  bit motor_stall = 1'b0, coin_stall = 1'b0, m_rand = 1'b0, c_rand = 1'b0;
  int m_delay = 3, c_delay = 1;

  always #5 clk = ~clk;

  vend_change_dispenser #(
    .FIFO_DEPTH (FIFO_DEPTH), .COIN_W (COIN_W), .INIT_COINS (INIT_COINS),
    .GAP (GAP), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk), .rst (rst), .out (out), .change (change), .refill (refill),
    .refill_cnt (refill_cnt), .clr_flags (clr_flags), .motor_req (motor_req),
    .motor_done (motor_done), .coin_req (coin_req), .coin_ack (coin_ack),
    .coins_left (coins_left), .busy (busy), .overflow (overflow),
    .short_change (short_change), .motor_fault (motor_fault)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a request yields a motor event if it vends, then one
  // coin event per 5 rs owed while stock lasts; running dry flags a shortage.
  task automatic model_req(input logic v, input logic [1:0] c);
    if (v || c != 2'd0) begin
      if (v) expq.push_back(EV_MOTOR);
      for (int k = 0; k < int'(c); k++) begin
        if (stock_m > 0) begin
          expq.push_back(EV_COIN);
          stock_m--;
        end else begin
          short_exp = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic observe(input int ev);
    int e;
    if (expq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: actual=%0d required=none (t=%0t)", ev, $time);
    end else begin
      e = expq.pop_front();
      check("event_order", ev, e);
    end
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int n = 0;
    while (busy === 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    check({name, "_idle"}, int'(busy), 0);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_coins"}, int'(coins_left), stock_m);
    check({tag, "_short"}, int'(short_change), int'(short_exp));
    check({tag, "_ovf"}, int'(overflow), int'(ovf_exp));
    check({tag, "_fault"}, int'(motor_fault), int'(fault_exp));
    check({tag, "_pending"}, expq.size(), 0);
  endtask

  task automatic do_refill(input int v);
    refill = 1'b1;
    refill_cnt = COIN_W'(v);
    tick();
    refill = 1'b0;
    stock_m = v;
  endtask

  task automatic do_clr();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    short_exp = 1'b0;
    ovf_exp = 1'b0;
    fault_exp = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Product motor model: acknowledges after a programmable number of cycles
  initial begin
    int mcnt, mlim;
    motor_done = 1'b0;
    mcnt = 0;
    mlim = 0;
    forever begin
      @(posedge clk);
      #1;
      if (motor_done) begin
        motor_done = 1'b0;
        mcnt = 0;
      end else if (motor_req && !motor_stall) begin
        if (mcnt == 0) mlim = m_rand ? int'($urandom_range(0, 4)) : m_delay;
        if (mcnt >= mlim) motor_done = 1'b1;
        else mcnt++;
      end else begin
        mcnt = 0;
      end
    end
  end

  // Coin hopper model: acknowledges each coin request after a delay
  initial begin
    int ccnt, clim;
    coin_ack = 1'b0;
    ccnt = 0;
    clim = 0;
    forever begin
      @(posedge clk);
      #1;
      if (coin_ack) begin
        coin_ack = 1'b0;
        ccnt = 0;
      end else if (coin_req && !coin_stall) begin
        if (ccnt == 0) clim = c_rand ? int'($urandom_range(0, 4)) : c_delay;
        if (ccnt >= clim) coin_ack = 1'b1;
        else ccnt++;
      end else begin
        ccnt = 0;
      end
    end
  end

  // Monitor: every motor start and every accepted coin is one event
  initial begin
    bit m_prev, c_prev, have_ack;
    int last_ack;
    m_prev = 1'b0; c_prev = 1'b0; have_ack = 1'b0; last_ack = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        m_prev = 1'b0; c_prev = 1'b0; have_ack = 1'b0;
      end else begin
        if (motor_req && !m_prev) observe(EV_MOTOR);
        if (coin_req && !c_prev && have_ack)
          check("coin_gap", int'((cyc - last_ack - 1) >= GAP), 1);
        if (coin_req && coin_ack) begin
          observe(EV_COIN);
          last_ack = cyc;
          have_ack = 1'b1;
        end
        m_prev = motor_req;
        c_prev = coin_req;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, hi, rv;
    logic v;
    logic [1:0] c;
    logic       v4 [6];
    logic [1:0] c4 [6];
    rst = 1'b1; out = 1'b0; change = 2'd0; refill = 1'b0; refill_cnt = '0;
    clr_flags = 1'b0;
    stock_m = INIT_COINS; short_exp = 1'b0; ovf_exp = 1'b0; fault_exp = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_motor_req", int'(motor_req), 0);
    check("rst_coin_req", int'(coin_req), 0);
    check("rst_busy", int'(busy), 0);
    check_state("rst");

    // Plain vend: motor_req two cycles after the strobe, done 3 cycles later
    out = 1'b1;
    model_req(1'b1, 2'd0);
    tick();
    out = 1'b0;
    check("lat_c1_motor", int'(motor_req), 0);
    tick();
    check("lat_c2_motor", int'(motor_req), 1);
    repeat (4) tick();
    check("t1_motor_low", int'(motor_req), 0);
    check("t1_coin_req", int'(coin_req), 0);
    check("t1_busy", int'(busy), 0);

    // Vend with 15 rs change: motor then three coins
    m_delay = 1;
    c_delay = 1;
    out = 1'b1; change = 2'b11;
    model_req(1'b1, 2'b11);
    tick();
    out = 1'b0; change = 2'b00;
    wait_idle(200, "t2");
    check("t2_coins_17", int'(coins_left), 17);
    check_state("t2");

    // Stock of one against 10 rs change: one coin, then shortage
    do_refill(1);
    change = 2'b10;
    model_req(1'b0, 2'b10);
    tick();
    change = 2'b00;
    wait_idle(200, "t3");
    check("t3_short", int'(short_change), 1);
    check("t3_coins_0", int'(coins_left), 0);
    check_state("t3");
    do_clr();
    check("t3_clr_short", int'(short_change), 0);

    // Six back-to-back strobes with the motor stalled: the sixth overflows
    do_refill(20);
    motor_stall = 1'b1;
    v4 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    c4 = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd1, 2'd3};
    for (int i = 0; i < 5; i++) begin
      out = v4[i]; change = c4[i];
      model_req(v4[i], c4[i]);
      tick();
    end
    check("t4_no_ovf_yet", int'(overflow), 0);
    out = v4[5]; change = c4[5];
    tick();
    out = 1'b0; change = 2'b00;
    ovf_exp = 1'b1;
    check("t4_ovf", int'(overflow), 1);
    motor_stall = 1'b0;
    wait_idle(500, "t4");
    check_state("t4");
    do_clr();
    check("t4_clr_ovf", int'(overflow), 0);

    // Motor never finishes: timeout, fault, change still paid
    motor_stall = 1'b1;
    out = 1'b1; change = 2'b01;
    model_req(1'b1, 2'b01);
    tick();
    out = 1'b0; change = 2'b00;
    n = 0;
    while (!motor_req && n < 10) begin tick(); n++; end
    check("t5_motor_start", int'(motor_req), 1);
    hi = 0;
    while (motor_req && hi < 600) begin
      tick();
      hi++;
      if (hi == TIMEOUT / 2) check("t5_fault_early", int'(motor_fault), 0);
    end
    check("t5_timeout_len", int'(hi >= TIMEOUT && hi <= TIMEOUT + 1), 1);
    fault_exp = 1'b1;
    check("t5_fault", int'(motor_fault), 1);
    motor_stall = 1'b0;
    wait_idle(200, "t5");
    check_state("t5");
    do_clr();
    check("t5_clr_fault", int'(motor_fault), 0);

    // Random bursts of up to FIFO_DEPTH requests, with refills and clears
    m_rand = 1'b1;
    c_rand = 1'b1;
    for (int b = 0; b < 40; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        rv = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 6)) : 20;
        do_refill(rv);
      end
      if ($urandom_range(0, 4) == 0) do_clr();
      n = int'($urandom_range(1, FIFO_DEPTH));
      for (int k = 0; k < n; k++) begin
        v = 1'($urandom_range(0, 1));
        c = 2'($urandom_range(0, 3));
        out = v; change = c;
        model_req(v, c);
        tick();
        if ($urandom_range(0, 2) == 0) begin
          out = 1'b0; change = 2'b00;
          tick();
        end
      end
      out = 1'b0; change = 2'b00;
      wait_idle(2000, "rnd");
      check_state("rnd");
    end

    // Reset while a coin request is outstanding
    m_rand = 1'b0;
    c_rand = 1'b0;
    do_refill(7);
    coin_stall = 1'b1;
    change = 2'b11;
    model_req(1'b0, 2'b11);
    tick();
    change = 2'b00;
    n = 0;
    while (!coin_req && n < 10) begin tick(); n++; end
    check("t6_coin_req_up", int'(coin_req), 1);
    rst = 1'b1;
    tick();
    check("t6_coin_req", int'(coin_req), 0);
    check("t6_motor_req", int'(motor_req), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_coins_init", int'(coins_left), INIT_COINS);
    rst = 1'b0;
    expq.delete();
    stock_m = INIT_COINS;
    short_exp = 1'b0; ovf_exp = 1'b0; fault_exp = 1'b0;
    coin_stall = 1'b0;
    repeat (10) tick();
    check("t6_quiet_busy", int'(busy), 0);
    check_state("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
